pid_move_ctrl: RTL
==================

# pid_move_ctrl

Sequencer that drives the PID steering datapath for one move command. It latches a square count, holds the robot stationary while the heading error settles, then ramps `frwrd` up to cruise speed. It counts line crossings, ramps `frwrd` back to zero, and signals completion. It owns the PID block's `moving` and `frwrd` inputs and paces every speed update on `err_vld`, the heading-valid strobe.

## Interface
Parameters:
- `FRWRD_INC`, default 10'd4: frwrd increment per `err_vld` during ramp-up.
- `FRWRD_DEC`, default 10'd8: frwrd decrement per `err_vld` during ramp-down.
- `MAX_SPD`, default 10'h2A0: cruise ceiling for frwrd.
- `ERR_THR`, default 12'd48: heading-settled threshold on |error|.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `cmd_vld`, input, 1: move command valid.
- `cmd_sqrs`, input, 4: unsigned squares to travel; 0 means align heading only.
- `cmd_rdy`, output, 1: block can accept a command.
- `err_vld`, input, 1: new heading error available (same strobe the PID block uses).
- `error`, input, 12: signed heading error.
- `line_pulse`, input, 1: one-cycle pulse per line crossing.
- `stop`, input, 1: abort request.
- `moving`, output, 1: drives PID `moving`.
- `frwrd`, output, 10: drives PID `frwrd`.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, HEAD, RAMP_UP, RAMP_DN. All outputs are registered.
- Internal registers:
  - `sqrs_q[3:0]`: latched square count.
  - `line_cnt[4:0]`: line crossings seen.
  - `abs_err[11:0]`: |error|. The value -2048 saturates to 12'h7FF and is never "settled".
- IDLE:
  - Outputs: `cmd_rdy`=1, `moving`=0, `frwrd`=0.
  - On `cmd_vld`: latch `cmd_sqrs`, clear `line_cnt`, go to HEAD.
- HEAD:
  - Outputs: `moving`=1, `frwrd`=0.
  - Exit only on `err_vld` with `abs_err < ERR_THR`:
    - if `sqrs_q`==0, go to IDLE and pulse `done`;
    - otherwise go to RAMP_UP.
  - `stop` in HEAD: go to IDLE immediately and pulse `done`.
  - `line_pulse` is ignored.
- RAMP_UP:
  - Output: `moving`=1.
  - On `err_vld`: `frwrd` <= min(`frwrd`+`FRWRD_INC`, `MAX_SPD`). Compute the sum at 11 bits before the clamp, so there is no wrap.
  - On `line_pulse`: `line_cnt`++.
  - When the incremented count equals 2·`sqrs_q`, go to RAMP_DN. The `frwrd` update of that same cycle still applies.
  - `stop`: go to RAMP_DN.
- RAMP_DN:
  - Output: `moving`=1.
  - On `err_vld`: `frwrd` <= (`frwrd` > `FRWRD_DEC`) ? `frwrd`-`FRWRD_DEC` : 0.
  - When the updated `frwrd` is 0: go to IDLE and pulse `done`.
  - If `frwrd` is already 0 on entry, exit on the next `err_vld`.
  - `line_pulse` and `stop` are ignored.
- Commands while busy: `cmd_vld` with `cmd_rdy`=0 is ignored and not queued.
- Simultaneous events:
  - `stop` has priority over the line-count exit (both lead to RAMP_DN).
  - `err_vld` and `line_pulse` in the same cycle are both applied.
- `done` and `cmd_rdy`: `done` is asserted the cycle IDLE is re-entered, and `cmd_rdy` rises in that same cycle.

## Timing
- Reset values: state IDLE, `cmd_rdy`=1, `moving`=0, `frwrd`=0, `done`=0, `line_cnt`=0, `sqrs_q`=0.
- Reset asserted mid-move forces all of the above on the next edge. `frwrd` drops to 0 without ramping.
- Command acceptance: `cmd_vld`&`cmd_rdy` at edge N gives `moving`=1 and `cmd_rdy`=0 from edge N+1.
- Settle check: a qualifying `err_vld` in HEAD at edge N gives the RAMP_UP state at N+1. The first increment needs a later `err_vld`.
- `frwrd` changes only on edges where `err_vld`=1.
- Ramp durations, in `err_vld` strobes: ramp-up to `MAX_SPD` takes ceil(`MAX_SPD`/`FRWRD_INC`) = 168; ramp-down from `MAX_SPD` takes 84.
- `done` is high for exactly one cycle. `moving` falls in the same cycle `done` rises.

## Test plan
- Reset check: assert `rst` for 2 cycles, then release → `cmd_rdy`=1, `moving`=0, `frwrd`=0, `done`=0.
- Heading-only move: `cmd_sqrs`=0; `error`=200 on 3 strobes, then 20 → `moving`=1 throughout with `frwrd`=0; after the `error`=20 strobe, `done` pulses once, and `moving` and `frwrd` are 0.
- One-square move:
  - `cmd_sqrs`=1, `error`=0, `err_vld` every 4 cycles.
  - Ramp-up: `frwrd` steps 4, 8, … and clamps at 0x2A0.
  - Two `line_pulse`s → ramp-down in steps of 8 to 0, then `done`.
- Early exit: `cmd_sqrs`=2; 4 `line_pulse`s arrive while `frwrd`=0x40 → ramp-down from 0x40; 8 strobes later `done`.
- Abort and busy command: `stop` while `frwrd`=0x100 in RAMP_UP → `frwrd` decrements to 0, then `done`. A `cmd_vld` presented mid-ramp is ignored (`sqrs_q` unchanged, no extra move afterward).
- Edge and mid-move reset: `error`=-2048 in HEAD never settles. `rst` asserted while in RAMP_UP → next cycle `frwrd`=0, `moving`=0, `cmd_rdy`=1.

Source files
------------

// File: rtl/pid_move_if.sv
// pid_move_if: command, heading and speed signals between the move sequencer and its environment.
interface pid_move_if;
  logic        cmd_vld;
  logic [3:0]  cmd_sqrs;
  logic        cmd_rdy;
  logic        err_vld;
  logic [11:0] error;
  logic        line_pulse;
  logic        stop;
  logic        moving;
  logic [9:0]  frwrd;
  logic        done;
  modport slave (
    input  cmd_vld, cmd_sqrs, err_vld, error, line_pulse, stop,
    output cmd_rdy, moving, frwrd, done
  );
  modport master (
    output cmd_vld, cmd_sqrs, err_vld, error, line_pulse, stop,
    input  cmd_rdy, moving, frwrd, done
  );
endinterface

// File: rtl/pid_move_ctrl.sv
// pid_move_ctrl: sequences one move command, ramping frwrd up and down on err_vld strobes.
module pid_move_ctrl #(
  parameter logic [9:0]  FRWRD_INC = 10'd4,
  parameter logic [9:0]  FRWRD_DEC = 10'd8,
  parameter logic [9:0]  MAX_SPD   = 10'h2A0,
  parameter logic [11:0] ERR_THR   = 12'd48
) (
  input  logic clk,
  input  logic rst,
  pid_move_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HEAD, RAMP_UP, RAMP_DN} state_e;
  state_e      state_q, state_d;
  logic [3:0]  sqrs_q, sqrs_d;
  logic [4:0]  line_cnt_q, line_cnt_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic        moving_q, cmd_rdy_q, done_q, done_d;
  logic [11:0] abs_err;
  logic [10:0] up_sum;
  logic [9:0]  up_val, dn_val;
  logic [4:0]  line_inc;
  // -2048 has no positive twin; saturate so it can never pass the settle check
  assign abs_err  = bus.error[11] ? ((bus.error == 12'h800) ? 12'h7FF : -bus.error) : bus.error;
  assign up_sum   = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
  assign up_val   = (up_sum > {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[9:0];
  assign dn_val   = (frwrd_q > FRWRD_DEC) ? frwrd_q - FRWRD_DEC : '0;
  assign line_inc = line_cnt_q + 5'd1;
  always_comb begin
    state_d    = state_q;
    sqrs_d     = sqrs_q;
    line_cnt_d = line_cnt_q;
    frwrd_d    = frwrd_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        frwrd_d = '0;
        if (bus.cmd_vld) begin
          sqrs_d     = bus.cmd_sqrs;
          line_cnt_d = '0;
          state_d    = HEAD;
        end
      end
      HEAD: begin
        frwrd_d = '0;
        if (bus.stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (bus.err_vld && abs_err < ERR_THR) begin
          state_d = (sqrs_q == 4'd0) ? IDLE : RAMP_UP;
          done_d  = (sqrs_q == 4'd0);
        end
      end
      RAMP_UP: begin
        frwrd_d    = bus.err_vld ? up_val : frwrd_q;
        line_cnt_d = bus.line_pulse ? line_inc : line_cnt_q;
        if (bus.stop || (bus.line_pulse && line_inc == {sqrs_q, 1'b0}))
          state_d = RAMP_DN;
      end
      RAMP_DN: begin
        if (bus.err_vld) begin
          frwrd_d = dn_val;
          state_d = (dn_val == '0) ? IDLE : RAMP_DN;
          done_d  = (dn_val == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sqrs_q     <= '0;
      line_cnt_q <= '0;
      frwrd_q    <= '0;
      moving_q   <= 1'b0;
      cmd_rdy_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sqrs_q     <= sqrs_d;
      line_cnt_q <= line_cnt_d;
      frwrd_q    <= frwrd_d;
      moving_q   <= (state_d != IDLE);
      cmd_rdy_q  <= (state_d == IDLE);
      done_q     <= done_d;
    end
  end
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.moving  = moving_q;
  assign bus.frwrd   = frwrd_q;
  assign bus.done    = done_q;
endmodule
